// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-stage address constants and FSM state encoding
package cpu_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
  localparam logic [31:0] IMEM_LO   = 32'h0000_3000;
  localparam logic [31:0] IMEM_HI   = 32'h0000_6FFC;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/npc_calc.sv
// rtl/npc_calc.sv - priority next-PC mux with jump and branch target arithmetic
module npc_calc
  import cpu_pkg::*;
#(
  parameter logic [31:0] EXC_ADDR = EXC_ENTRY
) (
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  input  logic [31:0] d_pc_i,
  input  logic        br_taken_i,
  input  logic [15:0] br_off_i,
  input  logic        j_i,
  input  logic [25:0] j_index_i,
  input  logic        jr_i,
  input  logic [31:0] jr_tgt_i,
  input  logic        exc_req_i,
  input  logic        eret_i,
  input  logic [31:0] epc_i,
  output logic [31:0] npc_o
);

  logic [31:0] seq_pc;
  logic [31:0] d_pc4;
  logic [31:0] j_tgt;
  logic [31:0] br_tgt;

  // Redirect targets are relative to the instruction in D, not to the fetch PC.
  assign seq_pc = pc_i + 32'd4;
  assign d_pc4  = d_pc_i + 32'd4;
  assign j_tgt  = {d_pc4[31:28], j_index_i, 2'b00};
  assign br_tgt = d_pc4 + {{14{br_off_i[15]}}, br_off_i, 2'b00};

  always_comb begin
    npc_o = seq_pc;
    if (exc_req_i) begin
      npc_o = EXC_ADDR;
    end else if (eret_i) begin
      npc_o = epc_i;
    end else if (stall_i) begin
      npc_o = pc_i;
    end else if (jr_i) begin
      npc_o = jr_tgt_i;
    end else if (j_i) begin
      npc_o = j_tgt;
    end else if (br_taken_i) begin
      npc_o = br_tgt;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - fetch PC register, BOOT/RUN FSM and fetch address check (PC_ALIGN_CHECK_EN)
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] BOOT_PC  = RESET_PC,
  parameter logic [31:0] EXC_ADDR = EXC_ENTRY
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_i,
  input  logic [31:0] d_pc_i,
  input  logic        br_taken_i,
  input  logic [15:0] br_off_i,
  input  logic        j_i,
  input  logic [25:0] j_index_i,
  input  logic        jr_i,
  input  logic [31:0] jr_tgt_i,
  input  logic        exc_req_i,
  input  logic        eret_i,
  input  logic [31:0] epc_i,
  output logic [31:0] pc_o,
  output logic        fetch_valid_o,
  output logic        flush_f_o,
  output logic        adel_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  npc;

  npc_calc #(
    .EXC_ADDR (EXC_ADDR)
  ) u_npc_calc (
    .pc_i       (pc_q),
    .stall_i    (stall_i),
    .d_pc_i     (d_pc_i),
    .br_taken_i (br_taken_i),
    .br_off_i   (br_off_i),
    .j_i        (j_i),
    .j_index_i  (j_index_i),
    .jr_i       (jr_i),
    .jr_tgt_i   (jr_tgt_i),
    .exc_req_i  (exc_req_i),
    .eret_i     (eret_i),
    .epc_i      (epc_i),
    .npc_o      (npc)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= BOOT;
      pc_q    <= BOOT_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // BOOT spends one cycle with the reset PC invalid and ignores every redirect.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_valid_o = 1'b0;
    flush_f_o     = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        fetch_valid_o = 1'b1;
        flush_f_o     = exc_req_i | eret_i;
        pc_d          = npc;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign pc_o = pc_q;

`ifdef PC_ALIGN_CHECK_EN
  assign adel_o = fetch_valid_o &
                  ((pc_q[1:0] != 2'b00) | (pc_q < IMEM_LO) | (pc_q > IMEM_HI));
`else
  assign adel_o = 1'b0;
`endif

endmodule
